// File: rtl/counter_array_rf_pkg.sv
// counter_array_rf_pkg
//   Shared register-map constants for the counter array register file.
//   Each channel owns two 64-bit registers: a counter and a status word.
//   The low index bit selects which of the two is addressed.
package counter_array_rf_pkg;

  localparam int REG_W = 64;

  // Low bit of the register index selects counter vs status.
  localparam logic CNT_OFS  = 1'b0;
  localparam logic STAT_OFS = 1'b1;

  // Bit positions inside the status word.
  localparam int OVF_BIT = 0;
  localparam int EN_BIT  = 1;

  // Build a status word as software sees it on read.
  function automatic logic [REG_W-1:0] stat_word(input logic ovf, input logic en);
    logic [REG_W-1:0] w;
    w          = '0;
    w[OVF_BIT] = ovf;
    w[EN_BIT]  = en;
    return w;
  endfunction

endpackage

// File: rtl/counter_array_rf_channel.sv
// counter_array_rf_channel
//   One counter channel: counter value, sticky overflow flag and
//   software enable.
// Ports:
//   clk, res      clock, synchronous active-high reset
//   hw_wen/data   hardware load (highest priority after reset)
//   countup       increment request (gated by sw_enable)
//   sw_cnt_wen    software write to the counter register
//   sw_cnt_data   value loaded by a software counter write
//   sw_stat_wen   software write to the status register
//   sw_ovf_clr    status write bit: 1 clears overflow
//   sw_en_data    status write bit: new sw_enable value
//   cnt, overflow, sw_enable   current state
module counter_array_rf_channel #(
  parameter int CNT_WIDTH = 48,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 hw_wen,
  input  logic [CNT_WIDTH-1:0] hw_data,
  input  logic                 countup,
  input  logic                 sw_cnt_wen,
  input  logic [CNT_WIDTH-1:0] sw_cnt_data,
  input  logic                 sw_stat_wen,
  input  logic                 sw_ovf_clr,
  input  logic                 sw_en_data,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 overflow,
  output logic                 sw_enable
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic                 r_en;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_inc;
  logic                 w_at_max;
  logic                 w_ovf_set;

  // An increment only takes effect when no load wins the same cycle,
  // so a load never raises the overflow flag.
  assign w_inc     = countup & r_en & ~hw_wen & ~sw_cnt_wen;
  assign w_at_max  = &r_cnt;
  assign w_ovf_set = w_inc & w_at_max;

  always_comb begin
    w_cnt_next = r_cnt;
    if (hw_wen) begin
      w_cnt_next = hw_data;
    end else if (sw_cnt_wen) begin
      w_cnt_next = sw_cnt_data;
    end else if (w_inc) begin
      if (!w_at_max) begin
        w_cnt_next = r_cnt + CNT_WIDTH'(1);
      end else if (!SATURATE) begin
        w_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_en  <= 1'b1;
    end else begin
      r_cnt <= w_cnt_next;
      // Set wins over a simultaneous W1C clear.
      r_ovf <= (r_ovf & ~(sw_stat_wen & sw_ovf_clr)) | w_ovf_set;
      if (sw_stat_wen) begin
        r_en <= sw_en_data;
      end
    end
  end

  assign cnt       = r_cnt;
  assign overflow  = r_ovf;
  assign sw_enable = r_en;

endmodule

// File: rtl/counter_array_rf.sv
// counter_array_rf
//   Array of NUM_CNT hardware counters with a 64-bit software register
//   interface. Index 2*i is counter i, index 2*i+1 is its status word
//   (bit0 overflow, W1C; bit1 sw_enable).
// Ports:
//   clk, res                 clock, synchronous active-high reset
//   address[7:3]             8-byte-aligned register index
//   read_en, write_en        software strobes (both at once = invalid)
//   write_data, read_data    software data (read_data registered, holds)
//   access_complete          one-cycle pulse, one cycle after a strobe
//   invalid_address          qualifies access_complete
//   cnt_next, cnt_wen        hardware load value / strobe per channel
//   cnt_countup              increment enable per channel
//   cnt, cnt_overflow        current counter values and overflow flags
module counter_array_rf
  import counter_array_rf_pkg::*;
#(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 48,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic [7:3]                     address,
  input  logic                           read_en,
  input  logic                           write_en,
  input  logic [REG_W-1:0]               write_data,
  output logic [REG_W-1:0]               read_data,
  output logic                           access_complete,
  output logic                           invalid_address,
  input  logic [NUM_CNT*CNT_WIDTH-1:0]   cnt_next,
  input  logic [NUM_CNT-1:0]             cnt_wen,
  input  logic [NUM_CNT-1:0]             cnt_countup,
  output logic [NUM_CNT*CNT_WIDTH-1:0]   cnt,
  output logic [NUM_CNT-1:0]             cnt_overflow
);

  // The 5-bit index spans 32 registers, i.e. up to 16 channels.
  localparam int MAX_CH  = 16;
  localparam int NUM_IDX = 2 * NUM_CNT;

  logic [4:0]       w_idx;
  logic [3:0]       w_ch;
  logic             w_sel;
  logic             w_in_range;
  logic             w_access;
  logic             w_valid;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic [REG_W-1:0] w_rd_word [2*MAX_CH];
  logic [REG_W-1:0] w_rd_mux;
  logic             w_ovf [NUM_CNT];
  logic             w_en  [NUM_CNT];

  logic [REG_W-1:0] r_read_data;
  logic             r_complete;
  logic             r_invalid;

  assign w_idx      = address;
  assign w_ch       = w_idx[4:1];
  assign w_sel      = w_idx[0];
  assign w_in_range = ({1'b0, w_idx} < 6'(NUM_IDX));
  assign w_access   = read_en | write_en;
  assign w_valid    = w_in_range & ~(read_en & write_en);
  assign w_rd_ok    = read_en & w_valid;
  assign w_wr_ok    = write_en & w_valid;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_ch
      if (gi < NUM_CNT) begin : g_used
        counter_array_rf_channel #(
          .CNT_WIDTH (CNT_WIDTH),
          .SATURATE  (SATURATE)
        ) u_channel (
          .clk         (clk),
          .res         (res),
          .hw_wen      (cnt_wen[gi]),
          .hw_data     (cnt_next[gi*CNT_WIDTH +: CNT_WIDTH]),
          .countup     (cnt_countup[gi]),
          .sw_cnt_wen  (w_wr_ok & (w_ch == 4'(gi)) & (w_sel == CNT_OFS)),
          .sw_cnt_data (write_data[CNT_WIDTH-1:0]),
          .sw_stat_wen (w_wr_ok & (w_ch == 4'(gi)) & (w_sel == STAT_OFS)),
          .sw_ovf_clr  (write_data[OVF_BIT]),
          .sw_en_data  (write_data[EN_BIT]),
          .cnt         (cnt[gi*CNT_WIDTH +: CNT_WIDTH]),
          .overflow    (w_ovf[gi]),
          .sw_enable   (w_en[gi])
        );
        assign cnt_overflow[gi]       = w_ovf[gi];
        assign w_rd_word[2*gi]        = REG_W'(cnt[gi*CNT_WIDTH +: CNT_WIDTH]);
        assign w_rd_word[2*gi+1]      = stat_word(w_ovf[gi], w_en[gi]);
      end else begin : g_unused
        assign w_rd_word[2*gi]        = '0;
        assign w_rd_word[2*gi+1]      = '0;
      end
    end
  endgenerate

  // Read mux sees pre-update state, so a read returns the value held in
  // the strobe cycle.
  assign w_rd_mux = w_rd_word[w_idx];

  always_ff @(posedge clk) begin
    if (res) begin
      r_read_data <= '0;
      r_complete  <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      r_complete <= w_access;
      r_invalid  <= w_access & ~w_valid;
      if (w_rd_ok) begin
        r_read_data <= w_rd_mux;
      end else if (w_access & ~w_valid) begin
        r_read_data <= '0;
      end
    end
  end

  assign read_data       = r_read_data;
  assign access_complete = r_complete;
  assign invalid_address = r_invalid;

  // Upper write_data bits are don't-care when CNT_WIDTH < 64.
  logic w_unused;
  assign w_unused = ^write_data;

endmodule

// File: tb/tb_counter_array_rf.sv
module tb_counter_array_rf;

  localparam int NC  = 4;
  localparam int W   = 48;
  localparam int SNC = 2;
  localparam int SW  = 4;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults)
  logic              res = 1'b1;
  logic [4:0]        addr = '0;
  logic              read_en = 1'b0, write_en = 1'b0;
  logic [63:0]       write_data = '0;
  logic [63:0]       read_data;
  logic              access_complete, invalid_address;
  logic [NC*W-1:0]   cnt_next = '0;
  logic [NC-1:0]     cnt_wen = '0, cnt_countup = '0;
  logic [NC*W-1:0]   cnt;
  logic [NC-1:0]     cnt_overflow;

  counter_array_rf #(.NUM_CNT(NC), .CNT_WIDTH(W), .SATURATE(1'b0)) dut (
    .clk(clk), .res(res), .address(addr), .read_en(read_en), .write_en(write_en),
    .write_data(write_data), .read_data(read_data), .access_complete(access_complete),
    .invalid_address(invalid_address), .cnt_next(cnt_next), .cnt_wen(cnt_wen),
    .cnt_countup(cnt_countup), .cnt(cnt), .cnt_overflow(cnt_overflow));

  // Two narrow instances sharing stimulus: wrap and saturate
  logic              s_res = 1'b1;
  logic [4:0]        s_addr = '0;
  logic              s_rd = 1'b0, s_wr = 1'b0;
  logic [63:0]       s_wd = '0;
  logic [SNC*SW-1:0] s_next = '0;
  logic [SNC-1:0]    s_wen = '0, s_up = '0;
  logic [63:0]       w_rdata, s_rdata;
  logic              w_ac, w_inv, s_ac, s_inv;
  logic [SNC*SW-1:0] w_cnt, s_cnt;
  logic [SNC-1:0]    w_ovf, s_ovf;

  counter_array_rf #(.NUM_CNT(SNC), .CNT_WIDTH(SW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .res(s_res), .address(s_addr), .read_en(s_rd), .write_en(s_wr),
    .write_data(s_wd), .read_data(w_rdata), .access_complete(w_ac),
    .invalid_address(w_inv), .cnt_next(s_next), .cnt_wen(s_wen),
    .cnt_countup(s_up), .cnt(w_cnt), .cnt_overflow(w_ovf));

  counter_array_rf #(.NUM_CNT(SNC), .CNT_WIDTH(SW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .res(s_res), .address(s_addr), .read_en(s_rd), .write_en(s_wr),
    .write_data(s_wd), .read_data(s_rdata), .access_complete(s_ac),
    .invalid_address(s_inv), .cnt_next(s_next), .cnt_wen(s_wen),
    .cnt_countup(s_up), .cnt(s_cnt), .cnt_overflow(s_ovf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [63:0] rd;
    bit          inv;
  } exp_t;
  exp_t exp_q[$];

  longint unsigned m_cnt [NC];
  bit              m_ovf [NC];
  bit              m_en  [NC];
  logic [63:0]     m_rd;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
      m_en[i]  = 1;
    end
    m_rd = '0;
  endtask

  // Apply the current inputs to the model, advance one clock, and compare
  // the counter outputs against the model.
  task automatic step();
    int  idx;
    bit  ok;
    bit  inc;
    bit  set;
    logic [3:0] ovf_vec;
    if (res) begin
      model_reset();
    end else begin
      idx = int'(addr);
      ok  = (idx < 2 * NC) && !(read_en && write_en);
      if (read_en || write_en) begin
        if (!ok)
          m_rd = '0;
        else if (read_en)
          m_rd = (idx % 2 == 0) ? 64'(m_cnt[idx/2])
                                : {62'd0, m_en[idx/2], m_ovf[idx/2]};
        exp_q.push_back('{m_rd, !ok});
      end
      for (int i = 0; i < NC; i++) begin
        inc = cnt_countup[i] && m_en[i];
        set = 0;
        if (cnt_wen[i])
          m_cnt[i] = 64'(cnt_next[i*W +: W]);
        else if (write_en && ok && idx == 2 * i)
          m_cnt[i] = write_data & MASK;
        else if (inc) begin
          if (m_cnt[i] == MASK) begin
            set = 1;
            m_cnt[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (write_en && ok && idx == 2 * i + 1) begin
          if (write_data[0]) m_ovf[i] = 0;
          m_en[i] = write_data[1];
        end
        if (set) m_ovf[i] = 1;
      end
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("cnt%0d", i), 64'(cnt[i*W +: W]), 64'(m_cnt[i]));
      ovf_vec[i] = m_ovf[i];
    end
    chk("cnt_overflow", 64'(cnt_overflow), 64'(ovf_vec));
  endtask

  // Monitor: runs 1 time unit after each edge, before the driver moves.
  exp_t        mon_e;
  logic [63:0] last_rd = '0;
  always begin
    @(posedge clk);
    #1;
    if (res) begin
      last_rd = '0;
      chk("rst_complete", 64'(access_complete), 64'd0);
      chk("rst_invalid", 64'(invalid_address), 64'd0);
      chk("rst_rdata", read_data, 64'd0);
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("complete", 64'(access_complete), 64'd1);
      chk("invalid", 64'(invalid_address), 64'(mon_e.inv));
      chk("rdata", read_data, mon_e.rd);
      last_rd = mon_e.rd;
      $display("txn: rdata=0x%0h invalid=%0d", read_data, invalid_address);
    end else begin
      chk("idle_complete", 64'(access_complete), 64'd0);
      chk("hold_rdata", read_data, last_rd);
    end
  end

  task automatic clear_inputs();
    read_en     = 1'b0;
    write_en    = 1'b0;
    cnt_wen     = '0;
    cnt_countup = '0;
  endtask

  task automatic s_step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    longint unsigned saved;
    model_reset();

    // ---- narrow instances: wrap vs saturate (main DUT held in reset) ----
    s_step(); s_step();
    s_res = 1'b0;
    chk("s_rst_cnt_wrap", 64'(w_cnt), 64'd0);
    chk("s_rst_cnt_sat", 64'(s_cnt), 64'd0);
    n = 17;
    s_up = 2'b01;
    for (int k = 0; k < n; k++) s_step();
    s_up = 2'b00;
    chk("wrap_value", 64'(w_cnt[SW-1:0]), 64'(n % 16));
    chk("wrap_ovf", 64'(w_ovf), 64'd1);
    chk("sat_value", 64'(s_cnt[SW-1:0]), 64'((n > 15) ? 15 : n));
    chk("sat_ovf", 64'(s_ovf), 64'd1);
    s_addr = 5'd1; s_wr = 1'b1; s_wd = 64'h3;
    s_step();
    s_wr = 1'b0;
    chk("w1c_ack_wrap", 64'(w_ac), 64'd1);
    chk("w1c_ack_sat", 64'(s_ac), 64'd1);
    chk("w1c_wrap", 64'(w_ovf), 64'd0);
    chk("w1c_sat", 64'(s_ovf), 64'd0);
    s_up = 2'b01;
    s_step();
    s_up = 2'b00;
    chk("sat_hold_value", 64'(s_cnt[SW-1:0]), 64'd15);
    chk("sat_reovf", 64'(s_ovf), 64'd1);
    chk("wrap_after_value", 64'(w_cnt[SW-1:0]), 64'((n + 1) % 16));
    chk("wrap_after_ovf", 64'(w_ovf), 64'd0);

    // ---- main instance ----
    clear_inputs();
    res = 1'b1; step();
    res = 1'b0;
    chk("rst_cnt_all", 64'(|cnt), 64'd0);

    // Status read after reset shows enable=1
    read_en = 1'b1; addr = 5'd3; step(); clear_inputs();

    // Count channel 0 for 200 cycles
    cnt_countup = 4'b0001;
    for (int k = 0; k < 200; k++) step();
    clear_inputs();
    chk("count200_ch0", 64'(cnt[W-1:0]), 64'd200);
    chk("count200_others", 64'(cnt[NC*W-1:W]), 64'd0);

    // HW load beats SW write and increment
    cnt_wen = 4'b0010; cnt_countup = 4'b0010;
    cnt_next[W +: W] = 48'd400;
    write_en = 1'b1; addr = 5'd2; write_data = 64'd7;
    step();
    chk("hwload_ch1", 64'(cnt[W +: W]), 64'd400);
    cnt_wen = '0; write_en = 1'b0;
    step();
    chk("hwload_then_inc", 64'(cnt[W +: W]), 64'd401);
    clear_inputs();

    // sw_enable gating on channel 2
    saved = 64'(cnt[2*W +: W]);
    write_en = 1'b1; addr = 5'd5; write_data = 64'h0; step(); clear_inputs();
    cnt_countup = 4'b0100;
    for (int k = 0; k < 10; k++) step();
    chk("disabled_ch2", 64'(cnt[2*W +: W]), saved);
    write_en = 1'b1; addr = 5'd5; write_data = 64'h2; step();
    write_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("resumed_ch2", 64'(cnt[2*W +: W]), saved + 3);
    clear_inputs();

    // Out-of-range and conflicting strobes
    read_en = 1'b1; addr = 5'd8; step(); clear_inputs();
    chk("oor_invalid", 64'(invalid_address), 64'd1);
    chk("oor_rdata", read_data, 64'd0);
    saved = 64'(cnt[W-1:0]);
    read_en = 1'b1; write_en = 1'b1; addr = 5'd0; write_data = 64'd999; step(); clear_inputs();
    chk("both_invalid", 64'(invalid_address), 64'd1);
    chk("both_no_write", 64'(cnt[W-1:0]), saved);

    // Read returns pre-increment value
    write_en = 1'b1; addr = 5'd0; write_data = 64'd50; step(); clear_inputs();
    read_en = 1'b1; addr = 5'd0; cnt_countup = 4'b0001; step(); clear_inputs();
    chk("read_pre_inc", read_data, 64'd50);
    chk("cnt_post_inc", 64'(cnt[W-1:0]), 64'd51);

    // Randomized traffic, with near-max values to provoke overflow
    for (int k = 0; k < 1500; k++) begin
      res      = ($urandom_range(0, 99) == 0);
      read_en  = ($urandom_range(0, 2) == 0);
      write_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) addr = 5'($urandom_range(0, 31));
      else                           addr = 5'($urandom_range(0, 7));
      write_data = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        write_data[W-1:0] = W'(MASK - 64'($urandom_range(0, 2)));
      if (addr[0] && $urandom_range(0, 3) != 0) write_data[1] = 1'b1;
      for (int i = 0; i < NC; i++) begin
        cnt_wen[i]     = ($urandom_range(0, 15) == 0);
        cnt_countup[i] = ($urandom_range(0, 3) != 0);
        cnt_next[i*W +: W] = ($urandom_range(0, 1) == 0)
                             ? W'(MASK - 64'($urandom_range(0, 3)))
                             : W'({$urandom, $urandom});
      end
      step();
    end
    res = 1'b0;
    clear_inputs();
    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
